// File: rtl/rvx_core_div_pkg.sv
// Shared constants, FSM encoding and operand helpers for the RV32M iterative divider.
package rvx_core_div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] RISCV_FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] RISCV_FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] RISCV_FUNCT3_REM  = 3'b110;
  localparam logic [2:0] RISCV_FUNCT3_REMU = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    RVX_DIV_IDLE = 2'd0,
    RVX_DIV_BUSY = 2'd1,
    RVX_DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } div_op_t;

  // Unrecognised funct3 values fall through to DIVU.
  function automatic div_op_t decode_op(input logic [2:0] f3);
    div_op_t op;
    op = '0;
    case (f3)
      RISCV_FUNCT3_DIV:  op.is_signed = 1'b1;
      RISCV_FUNCT3_REM:  begin op.is_signed = 1'b1; op.is_rem = 1'b1; end
      RISCV_FUNCT3_REMU: op.is_rem = 1'b1;
      default:           op = '0;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/rvx_core_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module rvx_core_div_step
  import rvx_core_div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dvd_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] dvs_ext;
  logic          qbit;

  // The shifted partial remainder needs XLEN+1 bits before the compare.
  always_comb begin
    shifted  = {rem, dvd[XLEN-1]};
    dvs_ext  = {1'b0, dvs};
    qbit     = (shifted >= dvs_ext);
    rem_next = qbit ? XLEN'(shifted - dvs_ext) : XLEN'(shifted);
    dvd_next = {dvd[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/rvx_core_div.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) stalling stage 2 until done.
module rvx_core_div
  import rvx_core_div_pkg::*;
#(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            div_start_s2,
  input  logic            flush_s2,
  input  logic [2:0]      funct3_s2,
  input  logic [XLEN-1:0] rs1_data_s2,
  input  logic [XLEN-1:0] rs2_data_s2,
  output logic            stall_div_s2,
  output logic            div_valid_s2,
  output logic [XLEN-1:0] div_output_s2
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic             special_q, special_d;
  logic [XLEN-1:0]  spec_res_q, spec_res_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  out_q, out_d;

  div_op_t          op_c;
  logic             div_zero_c;
  logic             overflow_c;
  logic             special_c;
  logic [XLEN-1:0]  spec_res_c;
  logic [XLEN-1:0]  step_rem_c;
  logic [XLEN-1:0]  step_dvd_c;
  logic [XLEN-1:0]  quot_fix_c;
  logic [XLEN-1:0]  rem_fix_c;
  logic [XLEN-1:0]  final_res_c;
  logic             stall_c;

  rvx_core_div_step u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .dvs      (dvs_q),
    .rem_next (step_rem_c),
    .dvd_next (step_dvd_c)
  );

  // Special-case detection on the incoming operands.
  always_comb begin
    op_c       = decode_op(funct3_s2);
    div_zero_c = (rs2_data_s2 == '0);
    overflow_c = op_c.is_signed && (rs1_data_s2 == INT_MIN) && (rs2_data_s2 == '1);
    special_c  = div_zero_c || overflow_c;
    if (div_zero_c) spec_res_c = op_c.is_rem ? rs1_data_s2 : '1;
    else            spec_res_c = op_c.is_rem ? '0 : INT_MIN;
  end

  // Sign fixup applied to the last iteration's outputs as they are captured.
  always_comb begin
    quot_fix_c  = neg_quot_q ? XLEN'(-step_dvd_c) : step_dvd_c;
    rem_fix_c   = neg_rem_q ? XLEN'(-step_rem_c) : step_rem_c;
    final_res_c = special_q ? spec_res_q : (is_rem_q ? rem_fix_c : quot_fix_c);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    valid_d    = 1'b0;
    out_d      = out_q;
    stall_c    = 1'b0;

    case (state_q)
      RVX_DIV_IDLE: begin
        if (div_start_s2 && !flush_s2) begin
          stall_c    = 1'b1;
          count_d    = CNT_W'(XLEN - 1);
          rem_d      = '0;
          dvd_d      = abs_val(rs1_data_s2, op_c.is_signed);
          dvs_d      = abs_val(rs2_data_s2, op_c.is_signed);
          neg_quot_d = op_c.is_signed && (rs1_data_s2[XLEN-1] ^ rs2_data_s2[XLEN-1]);
          neg_rem_d  = op_c.is_signed && rs1_data_s2[XLEN-1];
          is_rem_d   = op_c.is_rem;
          special_d  = special_c;
          spec_res_d = spec_res_c;
          if (FAST_SPECIAL && special_c) begin
            state_d = RVX_DIV_DONE;
            valid_d = 1'b1;
            out_d   = spec_res_c;
          end else begin
            state_d = RVX_DIV_BUSY;
          end
        end
      end
      RVX_DIV_BUSY: begin
        stall_c = 1'b1;
        if (flush_s2) begin
          state_d = RVX_DIV_IDLE;
          count_d = '0;
        end else begin
          rem_d = step_rem_c;
          dvd_d = step_dvd_c;
          if (count_q == '0) begin
            state_d = RVX_DIV_DONE;
            valid_d = 1'b1;
            out_d   = final_res_c;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      RVX_DIV_DONE: begin
        // Start is the same instruction retiring, so it is not re-accepted here.
        state_d = RVX_DIV_IDLE;
      end
      default: begin
        state_d = RVX_DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RVX_DIV_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      valid_q    <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
    end
  end

  assign stall_div_s2  = stall_c;
  assign div_valid_s2  = valid_q;
  assign div_output_s2 = out_q;

endmodule

// File: tb/tb_rvx_core_div.sv
// Directed self-checking bench for rvx_core_div with fast and full-iteration special handling.
module tb_rvx_core_div;

  logic        clock;
  logic        reset_n;
  logic        start_f, start_s;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall_f, valid_f, stall_s, valid_s;
  logic [31:0] out_f, out_s;

  int tests = 0;
  int fails = 0;

  rvx_core_div #(.FAST_SPECIAL(1'b1)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .div_start_s2  (start_f),
    .flush_s2      (flush),
    .funct3_s2     (funct3),
    .rs1_data_s2   (rs1),
    .rs2_data_s2   (rs2),
    .stall_div_s2  (stall_f),
    .div_valid_s2  (valid_f),
    .div_output_s2 (out_f)
  );

  rvx_core_div #(.FAST_SPECIAL(1'b0)) dut_slow (
    .clock         (clock),
    .reset_n       (reset_n),
    .div_start_s2  (start_s),
    .flush_s2      (flush),
    .funct3_s2     (funct3),
    .rs1_data_s2   (rs1),
    .rs2_data_s2   (rs2),
    .stall_div_s2  (stall_s),
    .div_valid_s2  (valid_s),
    .div_output_s2 (out_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, hold start while stalled, then check result, latency, stall span and hold.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input bit slow, input logic [31:0] exp,
                       input int exp_lat);
    int k;
    int stalls;
    bit got;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    if (slow) start_s = 1'b1;
    else      start_f = 1'b1;
    #1;
    k = 0;
    stalls = 0;
    got = 1'b0;
    while (!got && k < 60) begin
      if (slow ? stall_s : stall_f) stalls++;
      if (slow ? valid_s : valid_f) got = 1'b1;
      else begin
        @(posedge clock); #1;
        k++;
      end
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(k + 1), 32'(exp_lat));
    check({tag, "_stall"}, 32'(stalls), 32'(exp_lat - 1));
    check({tag, "_res"}, slow ? out_s : out_f, exp);
    start_f = 1'b0;
    start_s = 1'b0;
    @(posedge clock); #1;
    check({tag, "_vdrop"}, 32'(slow ? valid_s : valid_f), 32'd0);
    check({tag, "_hold"}, slow ? out_s : out_f, exp);
  endtask

  initial begin
    int vcount;
    reset_n = 1'b0;
    start_f = 1'b0;
    start_s = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    rs1     = 32'd0;
    rs2     = 32'd0;
    #12;
    check("rst_stall", 32'(stall_f), 32'd0);
    check("rst_valid", 32'(valid_f), 32'd0);
    check("rst_out", out_f, 32'd0);
    check("rst_out_slow", out_s, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    do_op("div_100_7",  3'b100, 32'd100, 32'd7, 1'b0, 32'd14, 34);
    do_op("rem_100_7",  3'b110, 32'd100, 32'd7, 1'b0, 32'd2, 34);
    do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 34);
    do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34);
    do_op("divu_big_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 34);

    // Flush in the tenth BUSY cycle.
    funct3  = 3'b100;
    rs1     = 32'd1000;
    rs2     = 32'd3;
    start_f = 1'b1;
    #1;
    repeat (10) begin
      @(posedge clock); #1;
    end
    check("flush_busy_stall", 32'(stall_f), 32'd1);
    flush   = 1'b1;
    start_f = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_idle_stall", 32'(stall_f), 32'd0);
    check("flush_idle_valid", 32'(valid_f), 32'd0);
    vcount = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (valid_f) vcount++;
    end
    check("flush_no_valid", 32'(vcount), 32'd0);
    check("flush_out_hold", out_f, 32'h7FFF_FFFC);
    do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 1'b0, 32'd3, 34);

    do_op("divu_5_0_fast", 3'b101, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 2);
    do_op("remu_5_0_fast", 3'b111, 32'd5, 32'd0, 1'b0, 32'd5, 2);
    do_op("divu_5_0_slow", 3'b101, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 34);
    do_op("remu_5_0_slow", 3'b111, 32'd5, 32'd0, 1'b1, 32'd5, 34);
    do_op("div_m7_0_slow", 3'b100, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 34);
    do_op("rem_m7_0_slow", 3'b110, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 34);
    do_op("div_ovf_fast",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 2);
    do_op("rem_ovf_fast",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 2);
    do_op("div_ovf_slow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 34);
    do_op("f3_unknown",    3'b000, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 34);

    // Asynchronous reset in the middle of BUSY.
    funct3  = 3'b101;
    rs1     = 32'd100;
    rs2     = 32'd7;
    start_f = 1'b1;
    #1;
    repeat (5) begin
      @(posedge clock); #1;
    end
    #2 reset_n = 1'b0;
    start_f = 1'b0;
    #1;
    check("arst_stall", 32'(stall_f), 32'd0);
    check("arst_valid", 32'(valid_f), 32'd0);
    check("arst_out", out_f, 32'd0);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    check("arst_idle_stall", 32'(stall_f), 32'd0);
    check("arst_idle_valid", 32'(valid_f), 32'd0);
    do_op("post_rst_divu", 3'b101, 32'd9, 32'd3, 1'b0, 32'd3, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
